// File: rtl/vdc_vram_sched_pkg.sv
// vdc_vram_sched_pkg: shared VRAM slot and scheduler types plus BG fetch slot positions.
package vdc_vram_sched_pkg;

   typedef enum logic [2:0] {SLOT_IDLE, SLOT_BAT, SLOT_CG0, SLOT_CG1, SLOT_CPU} vram_slot_t;
   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_RDWAIT} sched_state_t;

   localparam int CG1_OFS_DEF = 8;
   localparam logic [2:0] BAT_CYC = 3'd1;
   localparam logic [2:0] CG0_CYC = 3'd5;
   localparam logic [2:0] CG1_CYC = 3'd7;

   function automatic logic is_bg(input vram_slot_t s);
      return s == SLOT_BAT || s == SLOT_CG0 || s == SLOT_CG1;
   endfunction

endpackage

// File: rtl/vdc_slot_decode.sv
// vdc_slot_decode: maps character-cycle position to the VRAM slot owner; SLOT_CPU marks a free slot.
module vdc_slot_decode
   import vdc_vram_sched_pkg::*;
(
   input  logic [2:0] char_cycle_i,
   input  logic       active_i,
   output vram_slot_t slot_o
);

   always_comb
      slot_o = !active_i                ? SLOT_CPU :
               char_cycle_i == BAT_CYC ? SLOT_BAT :
               char_cycle_i == CG0_CYC ? SLOT_CG0 :
               char_cycle_i == CG1_CYC ? SLOT_CG1 : SLOT_CPU;

endmodule

// File: rtl/vdc_vram_sched.sv
// vdc_vram_sched: owns the character-cycle counter and the single VRAM port,
// interleaving fixed BG fetch slots with buffered CPU reads and writes.
module vdc_vram_sched
   import vdc_vram_sched_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int CG1_OFS = CG1_OFS_DEF
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              active_i,
   input  logic [ADDR_W-1:0] bat_addr_i,
   input  logic [ADDR_W-1:0] cg_addr_i,
   output logic [2:0]        char_cycle_o,
   output logic              bat_ld_o,
   output logic              cg0_ld_o,
   output logic              cg1_ld_o,
   input  logic              cpu_req_valid_i,
   input  logic              cpu_req_we_i,
   input  logic [ADDR_W-1:0] cpu_req_addr_i,
   input  logic [DATA_W-1:0] cpu_req_wdata_i,
   output logic              cpu_req_ready_o,
   output logic              cpu_rd_valid_o,
   output logic [DATA_W-1:0] cpu_rd_data_o,
   output logic              busy_n_o,
   output logic [ADDR_W-1:0] MA_o,
   output logic              vram_re_o,
   output logic              vram_we_o,
   output logic [DATA_W-1:0] MD_out_o,
   input  logic [DATA_W-1:0] MD_in_i
);

   sched_state_t      state_q, state_d;
   vram_slot_t        slot;
   logic [2:0]        char_cycle_q, char_cycle_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] md_out_q, md_out_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              bat_ld_q, cg0_ld_q, cg1_ld_q;
   logic              accept, cpu_issue, rd_ret;

   vdc_slot_decode u_slot (
      .char_cycle_i (char_cycle_q),
      .active_i     (active_i),
      .slot_o       (slot)
   );

   always_ff @(posedge clock or negedge reset_N)
      if (!reset_N) begin
         state_q      <= ST_IDLE;
         char_cycle_q <= 3'd0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         md_out_q     <= '0;
         rd_data_q    <= '0;
         bat_ld_q     <= 1'b0;
         cg0_ld_q     <= 1'b0;
         cg1_ld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         char_cycle_q <= char_cycle_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         md_out_q     <= md_out_d;
         rd_data_q    <= rd_data_d;
         bat_ld_q     <= slot == SLOT_BAT;
         cg0_ld_q     <= slot == SLOT_CG0;
         cg1_ld_q     <= slot == SLOT_CG1;
      end

   always_comb begin
      state_d = state_q == ST_IDLE ? (cpu_req_valid_i ? ST_PEND : ST_IDLE) :
                state_q == ST_PEND ? (slot != SLOT_CPU ? ST_PEND : we_q ? ST_IDLE : ST_RDWAIT) :
                ST_IDLE;
      char_cycle_d = active_i ? char_cycle_q + 3'd1 : 3'd0;
      we_d      = accept ? cpu_req_we_i    : we_q;
      addr_d    = accept ? cpu_req_addr_i  : addr_q;
      wdata_d   = accept ? cpu_req_wdata_i : wdata_q;
      md_out_d  = MD_out_o;
      rd_data_d = cpu_rd_data_o;
   end

   // The read result is forwarded from MD_in in its return cycle and held afterwards.
   always_comb begin
      accept          = state_q == ST_IDLE && cpu_req_valid_i;
      cpu_issue       = state_q == ST_PEND && slot == SLOT_CPU;
      rd_ret          = state_q == ST_RDWAIT;
      cpu_req_ready_o = state_q == ST_IDLE;
      busy_n_o        = state_q == ST_IDLE;
      cpu_rd_valid_o  = rd_ret;
      cpu_rd_data_o   = rd_ret ? MD_in_i : rd_data_q;
      MA_o = slot == SLOT_BAT ? bat_addr_i :
             slot == SLOT_CG0 ? cg_addr_i :
             slot == SLOT_CG1 ? cg_addr_i + ADDR_W'(CG1_OFS) :
             cpu_issue        ? addr_q : '0;
      vram_re_o    = is_bg(slot) || (cpu_issue && !we_q);
      vram_we_o    = cpu_issue && we_q;
      MD_out_o     = vram_we_o ? wdata_q : md_out_q;
      char_cycle_o = char_cycle_q;
      bat_ld_o     = bat_ld_q;
      cg0_ld_o     = cg0_ld_q;
      cg1_ld_o     = cg1_ld_q;
   end

endmodule
